// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit with an integrated hardware return-address stack.
// Supports sequential increment, absolute jump, PC-relative branch,
// subroutine call/return and interrupt entry. The PC is held as ADDR_W-1
// bits (halfword aligned); bit 0 of every address input is ignored.
//
// Configuration macro: PC_CALL_STACK_EN
//   defined   - return-address stack is built (CALL/IRQ push, RET pops).
//   undefined - no stack storage; CALL acts as JUMP, IRQ jumps without
//               saving the PC, RET holds the PC and flags underflow, and
//               stack_depth_out / return_addr_out / stack_overflow_out are 0.
//
// Ports:
//   clk_in              - clock, rising edge
//   reset_in            - asynchronous, active-high reset
//   pc_update_en_in     - execute pc_op_in this cycle
//   pc_op_in            - 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 IRQ,
//                         6/7 reserved (hold)
//   target_addr_in      - absolute target for JUMP and CALL
//   rel_offset_in       - signed byte offset for BRANCH
//   clear_err_in        - clears the sticky error flags
//   program_counter_out - current PC, bit 0 always 0
//   return_addr_out     - top-of-stack entry, 0 when empty
//   stack_depth_out     - number of valid stack entries
//   stack_overflow_out  - sticky: push while full
//   stack_underflow_out - sticky: RET while empty
// ---------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 16'h0000,
    parameter logic [ADDR_W-1:0] IRQ_VEC     = 16'h0004
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic                           pc_update_en_in,
    input  logic [2:0]                     pc_op_in,
    input  logic [ADDR_W-1:0]              target_addr_in,
    input  logic [ADDR_W-1:0]              rel_offset_in,
    input  logic                           clear_err_in,
    output logic [ADDR_W-1:0]              program_counter_out,
    output logic [ADDR_W-1:0]              return_addr_out,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth_out,
    output logic                           stack_overflow_out,
    output logic                           stack_underflow_out
);

    localparam int PW    = ADDR_W - 1;
    localparam int DW    = $clog2(STACK_DEPTH) + 1;
    localparam int PTR_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_IRQ    = 3'd5;

    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_d;
    logic [PW-1:0] pc_inc;
    logic          unf_q;
    logic          unf_set;

    // Address LSBs are architecturally ignored.
    logic unused_lsbs;
    assign unused_lsbs = target_addr_in[0] ^ rel_offset_in[0];

    // Halfword arithmetic modulo 2^(ADDR_W-1) equals byte arithmetic
    // modulo 2^ADDR_W with bit 0 forced to zero.
    assign pc_inc = pc_q + PW'(1);

`ifdef PC_CALL_STACK_EN
    logic [PW-1:0]    stack_q [STACK_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_inc;
    logic [DW-1:0]    depth_q;
    logic             ovf_q;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic [PW-1:0]    push_val;

    assign top_inc = top_q + PTR_W'(1);
`endif

    always_comb begin
        pc_d    = pc_q;
        unf_set = 1'b0;
`ifdef PC_CALL_STACK_EN
        push     = 1'b0;
        pop      = 1'b0;
        push_val = pc_inc;
`endif
        if (pc_update_en_in) begin
            case (pc_op_in)
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   pc_d = target_addr_in[ADDR_W-1:1];
                OP_BRANCH: pc_d = pc_q + rel_offset_in[ADDR_W-1:1];
                OP_CALL: begin
                    pc_d = target_addr_in[ADDR_W-1:1];
`ifdef PC_CALL_STACK_EN
                    push     = 1'b1;
                    push_val = pc_inc;
`endif
                end
                OP_RET: begin
`ifdef PC_CALL_STACK_EN
                    if (depth_q != '0) begin
                        pop  = 1'b1;
                        pc_d = stack_q[top_q];
                    end else begin
                        unf_set = 1'b1;
                    end
`else
                    unf_set = 1'b1;
`endif
                end
                OP_IRQ: begin
                    pc_d = IRQ_VEC[ADDR_W-1:1];
`ifdef PC_CALL_STACK_EN
                    // Save the interrupted instruction's own address.
                    push     = 1'b1;
                    push_val = pc_q;
`endif
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pc_q  <= RESET_VEC[ADDR_W-1:1];
            unf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            // A new error in the same cycle as a clear wins.
            if (unf_set)           unf_q <= 1'b1;
            else if (clear_err_in) unf_q <= 1'b0;
        end
    end

`ifdef PC_CALL_STACK_EN
    assign ovf_set = push && (depth_q == DW'(STACK_DEPTH));

    // Circular buffer: a push when full overwrites the slot after top,
    // which is exactly the oldest entry, so depth simply saturates.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
            top_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                stack_q[top_inc] <= push_val;
                top_q            <= top_inc;
                if (depth_q != DW'(STACK_DEPTH)) depth_q <= depth_q + DW'(1);
            end else if (pop) begin
                top_q   <= top_q - PTR_W'(1);
                depth_q <= depth_q - DW'(1);
            end
            if (ovf_set)           ovf_q <= 1'b1;
            else if (clear_err_in) ovf_q <= 1'b0;
        end
    end

    assign return_addr_out    = (depth_q == '0) ? '0 : {stack_q[top_q], 1'b0};
    assign stack_depth_out    = depth_q;
    assign stack_overflow_out = ovf_q;
`else
    assign return_addr_out    = '0;
    assign stack_depth_out    = '0;
    assign stack_overflow_out = 1'b0;
`endif

    assign program_counter_out = {pc_q, 1'b0};
    assign stack_underflow_out = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_unit
//
// Directed bench for pc_stack_unit with default parameters. The driver
// applies one op per cycle and pushes the hand-computed post-edge state
// into exp_q; a monitor pops one entry after every rising edge that has
// pending expectations and compares the full output state. Expectations
// follow whichever build of PC_CALL_STACK_EN is compiled.
// ---------------------------------------------------------------------------
module tb_pc_stack_unit;

    localparam int W = 16 + 16 + 3 + 1 + 1;

`ifdef PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BRA = 3'd2,
                           CAL = 3'd3, RET = 3'd4, IRQ = 3'd5, RSV = 3'd6;

    // ---------------- clock / reset ----------------
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        pc_update_en_in = 1'b0;
    logic [2:0]  pc_op_in = 3'd0;
    logic [15:0] target_addr_in = '0;
    logic [15:0] rel_offset_in = '0;
    logic        clear_err_in = 1'b0;
    logic [15:0] program_counter_out;
    logic [15:0] return_addr_out;
    logic [2:0]  stack_depth_out;
    logic        stack_overflow_out;
    logic        stack_underflow_out;

    always #5 clk_in = ~clk_in;

    pc_stack_unit dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .pc_update_en_in     (pc_update_en_in),
        .pc_op_in            (pc_op_in),
        .target_addr_in      (target_addr_in),
        .rel_offset_in       (rel_offset_in),
        .clear_err_in        (clear_err_in),
        .program_counter_out (program_counter_out),
        .return_addr_out     (return_addr_out),
        .stack_depth_out     (stack_depth_out),
        .stack_overflow_out  (stack_overflow_out),
        .stack_underflow_out (stack_underflow_out)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    always begin
        @(posedge clk_in);
        if (exp_q.size() > 0) begin
            logic [W-1:0] act;
            logic [W-1:0] exp;
            string        nm;
            #2;
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {program_counter_out, return_addr_out, stack_depth_out,
                   stack_overflow_out, stack_underflow_out};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got pc=%h ret=%h dep=%0d ovf=%b unf=%b, want pc=%h ret=%h dep=%0d ovf=%b unf=%b",
                         nm, act[36:21], act[20:5], act[4:2], act[1], act[0],
                         exp[36:21], exp[20:5], exp[4:2], exp[1], exp[0]);
            end
        end
    end

    // Stack-dependent expectations collapse to 0 when no stack is built.
    function automatic logic [15:0] s16(input logic [15:0] v);
        return STK ? v : 16'h0000;
    endfunction
    function automatic logic [2:0] s3(input logic [2:0] v);
        return STK ? v : 3'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input string nm, input logic rst, input logic en,
                        input logic [2:0] op, input logic [15:0] tgt,
                        input logic [15:0] off, input logic clr,
                        input logic [15:0] e_pc, input logic [15:0] e_ret,
                        input logic [2:0] e_dep, input logic e_ovf,
                        input logic e_unf);
        @(negedge clk_in);
        reset_in        = rst;
        pc_update_en_in = en;
        pc_op_in        = op;
        target_addr_in  = tgt;
        rel_offset_in   = off;
        clear_err_in    = clr;
        exp_q.push_back({e_pc, e_ret, e_dep, e_ovf, e_unf});
        name_q.push_back(nm);
    endtask

    initial begin
        // Reset and sequential increment
        step("reset",      1, 0, INC, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        step("idle0",      0, 0, INC, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        step("inc1",       0, 1, INC, 0, 0, 0, 16'h0002, 0, 0, 0, 0);
        step("dis_inc",    0, 0, INC, 0, 0, 0, 16'h0002, 0, 0, 0, 0);
        step("inc2",       0, 1, INC, 0, 0, 0, 16'h0004, 0, 0, 0, 0);
        step("dis_rsv",    0, 0, 3'd7, 0, 0, 0, 16'h0004, 0, 0, 0, 0);
        step("inc3",       0, 1, INC, 0, 0, 0, 16'h0006, 0, 0, 0, 0);
        // Jump, branch, wrap, reserved op
        step("jump",       0, 1, JMP, 16'h1235, 0, 0, 16'h1234, 0, 0, 0, 0);
        step("branch_neg", 0, 1, BRA, 0, 16'hFFFC, 0, 16'h1230, 0, 0, 0, 0);
        step("branch_0",   0, 1, BRA, 0, 16'h0000, 0, 16'h1230, 0, 0, 0, 0);
        step("jump_top",   0, 1, JMP, 16'hFFFE, 0, 0, 16'hFFFE, 0, 0, 0, 0);
        step("inc_wrap",   0, 1, INC, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        step("branch_odd", 0, 1, BRA, 0, 16'h0011, 0, 16'h0010, 0, 0, 0, 0);
        step("rsv_hold",   0, 1, RSV, 16'h4444, 0, 0, 16'h0010, 0, 0, 0, 0);
        // Nested call
        step("to_0100",    0, 1, JMP, 16'h0100, 0, 0, 16'h0100, 0, 0, 0, 0);
        step("call1",      0, 1, CAL, 16'h2000, 0, 0, 16'h2000, s16(16'h0102), s3(1), 0, 0);
        step("call2",      0, 1, CAL, 16'h3000, 0, 0, 16'h3000, s16(16'h2002), s3(2), 0, 0);
        step("ret1",       0, 1, RET, 0, 0, 0, STK ? 16'h2002 : 16'h3000,
             s16(16'h0102), s3(1), 0, !STK);
        step("ret2",       0, 1, RET, 0, 0, 0, STK ? 16'h0102 : 16'h3000, 0, 0, 0, !STK);
        step("clr_a",      0, 0, INC, 0, 0, 1, STK ? 16'h0102 : 16'h3000, 0, 0, 0, 0);
        // Interrupt
        step("to_0040",    0, 1, JMP, 16'h0040, 0, 0, 16'h0040, 0, 0, 0, 0);
        step("irq",        0, 1, IRQ, 0, 0, 0, 16'h0004, s16(16'h0040), s3(1), 0, 0);
        step("irq_ret",    0, 1, RET, 0, 0, 0, STK ? 16'h0040 : 16'h0004, 0, 0, 0, !STK);
        step("clr_b",      0, 0, INC, 0, 0, 1, STK ? 16'h0040 : 16'h0004, 0, 0, 0, 0);
        // Overflow: five calls into a four-entry stack
        step("to_0010",    0, 1, JMP, 16'h0010, 0, 0, 16'h0010, 0, 0, 0, 0);
        step("ocall1",     0, 1, CAL, 16'h0020, 0, 0, 16'h0020, s16(16'h0012), s3(1), 0, 0);
        step("ocall2",     0, 1, CAL, 16'h0030, 0, 0, 16'h0030, s16(16'h0022), s3(2), 0, 0);
        step("ocall3",     0, 1, CAL, 16'h0040, 0, 0, 16'h0040, s16(16'h0032), s3(3), 0, 0);
        step("ocall4",     0, 1, CAL, 16'h0050, 0, 0, 16'h0050, s16(16'h0042), s3(4), 0, 0);
        step("ocall5",     0, 1, CAL, 16'h0060, 0, 0, 16'h0060, s16(16'h0052), s3(4), STK, 0);
        step("oret1",      0, 1, RET, 0, 0, 0, STK ? 16'h0052 : 16'h0060,
             s16(16'h0042), s3(3), STK, !STK);
        step("oret2",      0, 1, RET, 0, 0, 0, STK ? 16'h0042 : 16'h0060,
             s16(16'h0032), s3(2), STK, !STK);
        step("oret3",      0, 1, RET, 0, 0, 0, STK ? 16'h0032 : 16'h0060,
             s16(16'h0022), s3(1), STK, !STK);
        step("oret4",      0, 1, RET, 0, 0, 0, STK ? 16'h0022 : 16'h0060, 0, 0, STK, !STK);
        step("oret5_unf",  0, 1, RET, 0, 0, 0, STK ? 16'h0022 : 16'h0060, 0, 0, STK, 1);
        // Clear coinciding with a new underflow: the set wins
        step("clr_set",    0, 1, RET, 0, 0, 1, STK ? 16'h0022 : 16'h0060, 0, 0, 0, 1);
        step("clr_all",    0, 0, INC, 0, 0, 1, STK ? 16'h0022 : 16'h0060, 0, 0, 0, 0);
        // Reset asserted while a CALL is presented
        step("to_0100b",   0, 1, JMP, 16'h0100, 0, 0, 16'h0100, 0, 0, 0, 0);
        step("rcall",      0, 1, CAL, 16'h2000, 0, 0, 16'h2000, s16(16'h0102), s3(1), 0, 0);
        step("rst_call",   1, 1, CAL, 16'h3000, 0, 0, 16'h0000, 0, 0, 0, 0);
        step("post_rst",   0, 0, CAL, 16'h3000, 0, 0, 16'h0000, 0, 0, 0, 0);
        // Call from the top of the address space wraps its return address
        step("to_fffe",    0, 1, JMP, 16'hFFFE, 0, 0, 16'hFFFE, 0, 0, 0, 0);
        step("call_wrap",  0, 1, CAL, 16'h0200, 0, 0, 16'h0200, 0, s3(1), 0, 0);
        step("ret_wrap",   0, 1, RET, 0, 0, 0, STK ? 16'h0000 : 16'h0200, 0, 0, 0, !STK);
        step("tail",       0, 0, INC, 0, 0, 0, STK ? 16'h0000 : 16'h0200, 0, 0, 0, !STK);

        @(negedge clk_in);
        pc_update_en_in = 1'b0;
        clear_err_in    = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_in);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit with an integrated hardware return-address stack, and the next-generation replacement for the CPU's single-mode PC. Besides sequential increment and absolute jump, it supports PC-relative branch, subroutine call/return and interrupt entry. It sits between the decoder/control FSM, which supplies the op and update strobe, and instruction fetch, which consumes `program_counter_out`.

## Interface
Parameters:
- `ADDR_W`, 16: address width in bits; must be ≥ 4.
- `STACK_DEPTH`, 4: return-stack entries; must be ≥ 2 and a power of two.
- `RESET_VEC`, 16'h0000: PC value after reset; bit 0 ignored.
- `IRQ_VEC`, 16'h0004: interrupt entry address; bit 0 ignored.

Ports:
- `clk_in`, input, 1: clock; all state updates on the rising edge.
- `reset_in`, input, 1: reset; asynchronous, active-high.
- `pc_update_en_in`, input, 1: executes `pc_op_in` this cycle.
- `pc_op_in`, input, 3: 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 IRQ; 6 and 7 reserved, treated as hold.
- `target_addr_in`, input, ADDR_W: absolute target for JUMP and CALL.
- `rel_offset_in`, input, ADDR_W: signed two's-complement byte offset for BRANCH.
- `clear_err_in`, input, 1: clears the sticky error flags.
- `program_counter_out`, output, ADDR_W: current PC; bit 0 is always 0.
- `return_addr_out`, output, ADDR_W: top-of-stack entry; 0 when the stack is empty.
- `stack_depth_out`, output, $clog2(STACK_DEPTH)+1: number of valid entries.
- `stack_overflow_out`, output, 1: sticky; a push occurred while the stack was full.
- `stack_underflow_out`, output, 1: sticky; a RET occurred while the stack was empty.

## Operation
- PC is stored as ADDR_W-1 bits, so it is halfword-aligned. Bit 0 of `target_addr_in`, `rel_offset_in`, `RESET_VEC` and `IRQ_VEC` is ignored.
- All arithmetic is modulo 2^ADDR_W. Wrap-around is silent: 0xFFFE + 2 = 0x0000.
- When `pc_update_en_in`=0, all state holds, including when `pc_op_in` is invalid.
- Ops, executed when `pc_update_en_in`=1:
  - INC: PC ← PC+2.
  - JUMP: PC ← target.
  - BRANCH: PC ← PC + offset, where PC is the address of the branch instruction itself. An offset of 0 is a self-loop.
  - CALL: push PC+2, then PC ← target.
  - RET: if depth>0, pop, then PC ← popped value. If depth=0, PC holds, set underflow, depth stays 0.
  - IRQ: push PC, the address of the interrupted instruction, then PC ← IRQ_VEC.
- Push when full (depth=STACK_DEPTH):
  - the oldest entry is discarded (circular buffer);
  - the new entry becomes top of stack;
  - depth stays STACK_DEPTH;
  - overflow flag is set.
- Stack is a circular buffer with a top pointer and a depth counter. A pop returns the most recent surviving entry.
- Sticky flags: `clear_err_in` clears both flags. If a new error occurs in the same cycle as `clear_err_in`, the set wins.

## Timing
- Reset values:
  - PC = RESET_VEC with bit 0 cleared;
  - depth = 0;
  - `return_addr_out` = 0;
  - both flags = 0;
  - stack entries cleared.
- Reset asserted mid-operation aborts any op immediately. No push or pop completes.
- Latency is 1 cycle. The new PC, depth and top of stack are visible after the rising edge that samples `pc_update_en_in`=1.
- Outputs are taken directly from registers, or from a register-selected stack entry for `return_addr_out`. There is no combinational path from the inputs to the outputs.
- Back-to-back ops every cycle are supported. CALL followed directly by RET returns to the CALL's PC+2 on the second edge.

## Configuration
- `PC_CALL_STACK_EN`, defined: full behaviour as described above.
- `PC_CALL_STACK_EN`, undefined: no stack storage is built.
  - CALL behaves as JUMP.
  - IRQ jumps to IRQ_VEC without saving the PC.
  - RET holds the PC and sets `stack_underflow_out`.
  - `stack_depth_out`, `return_addr_out` and `stack_overflow_out` are tied to 0.

## Test plan
All scenarios use the default parameters unless stated.
- **Reset:** reset, then INC ×3 → PC 0x0000, 0x0002, 0x0004, 0x0006. Disabled cycles in between leave the PC unchanged.
- **Jump and branch:** JUMP target=0x1235 → PC 0x1234. BRANCH offset=0xFFFC → PC 0x1230. INC at 0xFFFE → PC 0x0000.
- **Nested call:** at PC 0x0100, CALL 0x2000 → PC 0x2000, depth 1, return_addr 0x0102. CALL 0x3000 → depth 2, return_addr 0x2002. RET → PC 0x2002. RET → PC 0x0102, depth 0.
- **Interrupt:** at PC 0x0040, IRQ → PC 0x0004, return_addr 0x0040. RET → PC 0x0040.
- **Overflow:** five CALLs at PCs 0x10/0x20/0x30/0x40/0x50 → overflow=1, depth 4. Four RETs → 0x52, 0x42, 0x32, 0x22. Fifth RET → PC holds, underflow=1. `clear_err_in` → both flags 0.
- **Reset mid-operation and macro off:** reset asserted while CALL is active → PC=RESET_VEC, depth 0. With the macro undefined, CALL 0x2000 → PC 0x2000, depth 0, and RET sets underflow.
